// File: rtl/binary_multiplier_4bit.sv
// Sequential shift-and-add unsigned multiplier with a Ready/Start handshake.
// Controller walks S_idle -> (S_add -> S_shift) x WIDTH -> S_idle.
module binary_multiplier_4bit #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic [WIDTH-1:0]     Multiplier,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Ready,
    output logic                 Done
);

    typedef enum logic [1:0] {
        S_idle  = 2'd0,
        S_add   = 2'd1,
        S_shift = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               c_reg;
    logic [CNT_W-1:0]   p_reg;
    logic               done_reg;

    logic [WIDTH-1:0]   sum_next;
    logic               carry_next;

    // Ripple-carry adder stage feeding the accumulator: A + B with carry-out.
    always_comb begin : ripple
        logic cy;
        cy       = 1'b0;
        sum_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_next[i] = a_reg[i] ^ b_reg[i] ^ cy;
            cy          = (a_reg[i] & b_reg[i]) | (cy & (a_reg[i] ^ b_reg[i]));
        end
        carry_next = cy;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= S_idle;
            a_reg     <= '0;
            q_reg     <= '0;
            b_reg     <= '0;
            c_reg     <= 1'b0;
            p_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_idle: begin
                    if (Start) begin
                        b_reg     <= Multiplicand;
                        q_reg     <= Multiplier;
                        a_reg     <= '0;
                        c_reg     <= 1'b0;
                        p_reg     <= CNT_W'(WIDTH);
                        state_reg <= S_add;
                    end
                end
                S_add: begin
                    if (q_reg[0]) begin
                        {c_reg, a_reg} <= {carry_next, sum_next};
                    end else begin
                        c_reg <= 1'b0;
                    end
                    p_reg     <= p_reg - 1'b1;
                    state_reg <= S_shift;
                end
                S_shift: begin
                    // Carry drops into the top of A, A[0] into the top of Q.
                    {c_reg, a_reg, q_reg} <= {1'b0, c_reg, a_reg, q_reg[WIDTH-1:1]};
                    if (p_reg == '0) begin
                        state_reg <= S_idle;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= S_add;
                    end
                end
                default: state_reg <= S_idle;
            endcase
        end
    end

    assign Product = {a_reg, q_reg};
    assign Ready   = (state_reg == S_idle);
    assign Done    = done_reg;

endmodule

// File: tb/tb_binary_multiplier_4bit.sv
// Scoreboarded bench for binary_multiplier_4bit: expected products are queued
// when a Start is accepted and checked whenever Done pulses.
module tb_binary_multiplier_4bit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       Start = 1'b0;
    logic [3:0] Multiplicand = '0;
    logic [3:0] Multiplier = '0;
    logic [7:0] Product;
    logic       Ready;
    logic       Done;

    int         vec_cnt  = 0;
    int         err_cnt  = 0;
    int         done_cnt = 0;
    logic [7:0] sb_q[$];

    binary_multiplier_4bit #(.WIDTH(4), .CNT_W(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .Start        (Start),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .Ready        (Ready),
        .Done         (Done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Push the expected product when the coming edge will accept a Start.
    always @(negedge clock) begin
        logic [7:0] exp_p;
        if (reset === 1'b0 && Ready === 1'b1 && Start === 1'b1) begin
            exp_p = {4'b0, Multiplicand} * {4'b0, Multiplier};
            sb_q.push_back(exp_p);
        end
    end

    always @(negedge clock) begin
        if (Done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
            else                  check("sb_product", {24'd0, Product}, {24'd0, sb_q.pop_front()});
        end
    end

    task automatic pulse_start(input logic [3:0] b, input logic [3:0] m);
        @(posedge clock); #1;
        Multiplicand = b;
        Multiplier   = m;
        Start        = 1'b1;
        @(posedge clock); #1;
        Start = 1'b0;
    endtask

    task automatic wait_idle(output int busy);
        int n;
        n = 0;
        @(negedge clock);
        while (Ready !== 1'b1 && n < 40) begin
            n++;
            @(negedge clock);
        end
        busy = n;
        if (Ready !== 1'b1) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_job(input string tag, input logic [3:0] b, input logic [3:0] m,
                           input logic [7:0] exp_p);
        int busy;
        pulse_start(b, m);
        wait_idle(busy);
        check({tag, "_busy"}, busy, 32'd8);
        check({tag, "_done"}, {31'd0, Done}, 32'd1);
        check({tag, "_prod"}, {24'd0, Product}, {24'd0, exp_p});
        @(negedge clock);
        check({tag, "_done_fall"}, {31'd0, Done}, 32'd0);
        check({tag, "_hold"}, {24'd0, Product}, {24'd0, exp_p});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        int n;
        int d0;

        // Reset and idle hold
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_ready", {31'd0, Ready}, 32'd1);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_prod", {24'd0, Product}, 32'd0);
        repeat (5) @(negedge clock);
        check("idle_prod", {24'd0, Product}, 32'd0);

        run_job("d_x_b", 4'b1101, 4'b1011, 8'h8F);

        // Carry path with internal accumulator checks
        pulse_start(4'hF, 4'hF);
        @(negedge clock);
        @(negedge clock);
        check("ff_add1_a", {28'd0, dut.a_reg}, 32'hF);
        check("ff_add1_c", {31'd0, dut.c_reg}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        check("ff_add2_c", {31'd0, dut.c_reg}, 32'd1);
        check("ff_add2_a", {28'd0, dut.a_reg}, 32'h6);
        wait_idle(busy);
        check("ff_busy_tail", busy, 32'd4);
        check("ff_prod", {24'd0, Product}, 32'hE1);

        run_job("zero_b", 4'h0, 4'h9, 8'h00);
        run_job("zero_q", 4'h9, 4'h0, 8'h00);

        // Start held high, operands changed while busy
        @(posedge clock); #1;
        Multiplicand = 4'h5;
        Multiplier   = 4'h6;
        Start        = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        Multiplicand = 4'h2;
        Multiplier   = 4'h3;
        n = 0;
        @(negedge clock);
        while (Done !== 1'b1 && n < 20) begin
            n++;
            @(negedge clock);
        end
        check("hold_done1", {31'd0, Done}, 32'd1);
        check("hold_prod1", {24'd0, Product}, 32'h1E);
        @(posedge clock); #1;
        Start = 1'b0;
        @(negedge clock);
        check("hold_relaunch", {31'd0, Ready}, 32'd0);
        wait_idle(busy);
        check("hold_busy2", busy, 32'd7);
        check("hold_prod2", {24'd0, Product}, 32'h06);

        // Abort mid-operation with reset
        pulse_start(4'h7, 4'h7);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        sb_q.delete();
        d0 = done_cnt;
        @(negedge clock);
        check("abort_ready", {31'd0, Ready}, 32'd1);
        check("abort_prod", {24'd0, Product}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        repeat (10) @(negedge clock);
        check("abort_no_pulse", done_cnt, d0);

        run_job("after_abort", 4'h7, 4'h7, 8'h31);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
